// File: rtl/shift128to8_if.sv
// Block-load / byte-stream handshake bundle for the SM4 output serialiser.
// slave is the serialiser's view, master is the driver/sink side.
interface shift128to8_if #(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport slave (
    input  load_valid,
    input  data_in,
    input  out_ready,
    output load_ready,
    output out_valid,
    output data_out,
    output busy,
    output done
  );

  modport master (
    output load_valid,
    output data_in,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  data_out,
    input  busy,
    input  done
  );
endinterface

// File: rtl/shift128to8.sv
// SM4 output serialiser: one 128-bit block out as 16 bytes, MSB byte first.
// A new block may load on the last-byte handshake, so streams run gap-free.
module shift128to8 #(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  shift128to8_if.slave  bus
);
  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              last;
  logic              load_hs;
  logic              out_hs;

  assign last    = (cnt_q == LAST);
  assign load_hs = bus.load_valid & bus.load_ready;
  assign out_hs  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_hs) state_d = SHIFT;
      end
      SHIFT: begin
        if (out_hs && last && !load_hs)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // load_ready is held low during reset so no block is taken then
  always_comb begin
    bus.load_ready = 1'b0;
    bus.out_valid  = 1'b0;
    bus.busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.load_ready = !rst;
      end
      SHIFT: begin
        bus.load_ready = !rst && last && bus.out_ready;
        bus.out_valid  = 1'b1;
        bus.busy       = 1'b1;
      end
      default: ;
    endcase
    bus.data_out = shift_q[DATA_W-1 -: BYTE_W];
    bus.done     = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= out_hs && last;
      if (load_hs) begin
        shift_q <= bus.data_in;
        cnt_q   <= '0;
      end else if (out_hs) begin
        shift_q <= shift_q << BYTE_W;
        cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_shift128to8.sv
// Bench for shift128to8: scoreboard of expected bytes and blocks,
// with a byte collector rebuilding each 128-bit block from the stream.
module tb_shift128to8;
  logic clk;
  logic rst;

  shift128to8_if #(.DATA_W(128), .BYTE_W(8)) sif ();

  shift128to8 #(.DATA_W(128), .BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   exp_q[$];
  logic [127:0] blk_q[$];

  logic [127:0] col;
  int           nb = 0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_byte;
  int           stalls = 0;

  localparam logic [127:0] BLK_A =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_C =
    128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK_D =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] BLK_E =
    128'h5A0F_3C96_A5F0_C369_1248_8421_7E81_E718;

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 16; i++)
      exp_q.push_back(b[127 - 8*i -: 8]);
    blk_q.push_back(b);
  endtask

  // Stream monitor: byte order, block rebuild, stall stability
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      blk_q.delete();
      nb = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (sif.out_valid !== 1'b1 || sif.data_out !== prev_byte) begin
          tests_failed++;
          $display("FAIL stall_hold: valid=%b byte=%h want valid=1 byte=%h",
                   sif.out_valid, sif.data_out, prev_byte);
        end
      end
      if (sif.out_valid && sif.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL byte_unexpected: got %h want no byte",
                   sif.data_out);
        end else begin
          logic [7:0] eb;
          eb = exp_q.pop_front();
          if (sif.data_out !== eb) begin
            tests_failed++;
            $display("FAIL byte_value: got %h want %h", sif.data_out, eb);
          end
        end
        col = {col[119:0], sif.data_out};
        nb++;
        if (nb == 16) begin
          nb = 0;
          tests_run++;
          if (blk_q.size() == 0) begin
            tests_failed++;
            $display("FAIL block_unexpected: got %h want none", col);
          end else begin
            logic [127:0] eblk;
            eblk = blk_q.pop_front();
            if (col !== eblk) begin
              tests_failed++;
              $display("FAIL block_rebuild: got %h want %h", col, eblk);
            end
          end
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_byte  = sif.data_out;
      if (prev_stall) stalls++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    sif.load_valid = 1'b1;
    sif.data_in = BLK_D;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (sif.out_valid !== 1'b0 || sif.done !== 1'b0 ||
        sif.busy !== 1'b0 || sif.data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: v=%b d=%b b=%b q=%h want 0 0 0 00",
               sif.out_valid, sif.done, sif.busy, sif.data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sif.load_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sif.load_ready !== 1'b1 || sif.out_valid !== 1'b0 ||
        sif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: lr=%b v=%b b=%b want 1 0 0",
               sif.load_ready, sif.out_valid, sif.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int first_v = -1;
    int done_at = -1;
    int done_n  = 0;
    int nvalid  = 0;
    sif.out_ready = 1'b1;
    sif.data_in = BLK_A;
    sif.load_valid = 1'b1;
    push_block(BLK_A);
    @(negedge clk);
    tests_run++;
    if (sif.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_load_ready: got %b want 1", sif.load_ready);
    end
    @(posedge clk); #1;
    sif.load_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sif.out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
      end
      if (sif.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i == 16) begin
        tests_run++;
        if (sif.load_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_lr_last: got %b want 1", sif.load_ready);
        end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (first_v != 1 || nvalid != 16) begin
      tests_failed++;
      $display("FAIL single_timing: first=%0d n=%0d want 1 16",
               first_v, nvalid);
    end
    tests_run++;
    if (done_at != 17 || done_n != 1) begin
      tests_failed++;
      $display("FAIL single_done: at=%0d n=%0d want 17 1",
               done_at, done_n);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int done_n = 0;
    int st0 = stalls;
    sif.out_ready = 1'b1;
    sif.data_in = BLK_C;
    sif.load_valid = 1'b1;
    push_block(BLK_C);
    @(negedge clk);
    @(posedge clk); #1;
    sif.load_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sif.out_ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
      if (sif.done) begin
        done_n++;
        tests_run++;
        if (hs != 16) begin
          tests_failed++;
          $display("FAIL bp_done_pos: hs=%0d want 16", hs);
        end
      end
      if (sif.out_valid && sif.out_ready) hs++;
      @(posedge clk); #1;
    end
    sif.out_ready = 1'b1;
    tests_run++;
    if (hs != 16 || done_n != 1) begin
      tests_failed++;
      $display("FAIL bp_counts: hs=%0d done=%0d want 16 1", hs, done_n);
    end
    tests_run++;
    if (stalls - st0 < 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_stalls: stalls=%0d left=%0d want >=8 0",
               stalls - st0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    int done_n = 0;
    logic d17 = 1'b0;
    logic d33 = 1'b0;
    logic [127:0] b;
    b = ~BLK_A;
    sif.out_ready = 1'b1;
    sif.data_in = BLK_A;
    sif.load_valid = 1'b1;
    push_block(BLK_A);
    @(negedge clk);
    @(posedge clk); #1;
    sif.data_in = b;
    push_block(b);
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (i <= 32 && !sif.out_valid) gaps++;
      if (sif.done) begin
        done_n++;
        if (i == 17) d17 = 1'b1;
        if (i == 33) d33 = 1'b1;
      end
      if (i == 16) begin
        tests_run++;
        if (sif.load_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_lr: got %b want 1", sif.load_ready);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (sif.data_out !== 8'hFF || sif.out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_first_b: got %h v=%b want ff v=1",
                   sif.data_out, sif.out_valid);
        end
      end
      @(posedge clk); #1;
      if (i == 16) sif.load_valid = 1'b0;
    end
    tests_run++;
    if (gaps != 0) begin
      tests_failed++;
      $display("FAIL b2b_gaps: got %0d want 0", gaps);
    end
    tests_run++;
    if (!d17 || !d33 || done_n != 2) begin
      tests_failed++;
      $display("FAIL b2b_done: d17=%b d33=%b n=%0d want 1 1 2",
               d17, d33, done_n);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_load_busy();
    int done_n = 0;
    int done_at = -1;
    sif.out_ready = 1'b1;
    sif.data_in = BLK_C;
    sif.load_valid = 1'b1;
    push_block(BLK_C);
    @(negedge clk);
    @(posedge clk); #1;
    sif.load_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        tests_run++;
        if (sif.load_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_lr: got %b want 0", sif.load_ready);
        end
      end
      if (sif.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      @(posedge clk); #1;
      if (i == 4) begin
        sif.load_valid = 1'b1;
        sif.data_in = BLK_D;
      end
      if (i == 5) sif.load_valid = 1'b0;
    end
    tests_run++;
    if (done_n != 1 || done_at != 17 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL busy_done: n=%0d at=%0d left=%0d want 1 17 0",
               done_n, done_at, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    sif.out_ready = 1'b1;
    sif.data_in = BLK_A;
    sif.load_valid = 1'b1;
    push_block(BLK_A);
    @(negedge clk);
    @(posedge clk); #1;
    sif.load_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) begin
        tests_run++;
        if (sif.out_valid !== 1'b0 || sif.done !== 1'b0 ||
            sif.busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL rst_mid_out: v=%b d=%b b=%b want 0 0 0",
                   sif.out_valid, sif.done, sif.busy);
        end
      end
      @(posedge clk); #1;
      if (i == 6) rst = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sif.done) done_n++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (done_n != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_nodone: got %0d want 0", done_n);
    end
    sif.data_in = BLK_E;
    sif.load_valid = 1'b1;
    push_block(BLK_E);
    @(negedge clk);
    @(posedge clk); #1;
    sif.load_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sif.done) done_n++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (done_n != 1 || exp_q.size() != 0 || blk_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_fresh: done=%0d left=%0d blk=%0d want 1 0 0",
               done_n, exp_q.size(), blk_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.load_valid = 1'b0;
    sif.out_ready = 1'b0;
    sif.data_in = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_load_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
